dual_port_memory: RTL and testbench
===================================

DUAL_PORT_MEMORY -- requirements
Module: dual_port_memory

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, data/address width in bits.
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of words; a power of two no greater than 2^WORD_SIZE.
REQ-003 SHALL have parameter INIT_VALUE, default 16'h0000, value written to every word during initialisation.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port read_m1  input  1  instruction-port read request.
REQ-007 SHALL have port address1  input  WORD_SIZE  instruction-port word address.
REQ-008 SHALL have port data1  output  WORD_SIZE  instruction-port read data.
REQ-009 SHALL have port read_m2  input  1  data-port read request.
REQ-010 SHALL have port write_m2  input  1  data-port write request.
REQ-011 SHALL have port address2  input  WORD_SIZE  data-port word address.
REQ-012 SHALL have port data2  inout  WORD_SIZE  bidirectional data bus: driven by the block on reads, driven by the requester on writes.
REQ-013 SHALL have port mem_ready  output  1  high once initialisation is complete.
REQ-014 SHALL have port num_reads  output  WORD_SIZE  count of accepted reads on both ports.
REQ-015 SHALL have port num_writes  output  WORD_SIZE  count of accepted writes.
REQ-016 SHALL have port conflict  output  1  sticky flag: read_m2 and write_m2 were both high in the same cycle.

Function
REQ-017 SHALL implement a two-state FSM: INIT and READY.
REQ-018 In INIT, an index counter SHALL step from 0 to MEM_DEPTH-1 and write INIT_VALUE to one word per cycle.
REQ-019 When the index counter reaches MEM_DEPTH-1, the FSM SHALL enter READY on the next edge, so mem_ready rises exactly MEM_DEPTH cycles after reset release.
REQ-020 Only a reset SHALL cause an exit from READY.
REQ-021 The word index SHALL be address[log2(MEM_DEPTH)-1:0]; upper address bits are ignored, so addresses wrap modulo MEM_DEPTH.
REQ-022 In READY, data1 SHALL combinationally equal mem[address1] when read_m1=1, else 0; zero-latency, so the requester samples it at its next edge.
REQ-023 In READY, when read_m2=1 and write_m2=0, data2 SHALL combinationally drive mem[address2]; in all other cases data2 SHALL be high-impedance.
REQ-024 In READY, when write_m2=1, the data2 bus value SHALL be written to mem[address2] at the rising edge.
REQ-025 On a same-cycle port-1 read of a word being written by port 2, data1 SHALL return the old value before the edge and the new value after it; no forwarding.
REQ-026 When read_m2 and write_m2 are both 1, the write SHALL take effect, data2 SHALL not be driven, and conflict SHALL be set and held until reset.
REQ-027 In INIT, all requests SHALL be ignored: data1=0, data2 high-Z, no writes, no count changes.
REQ-028 num_reads SHALL add (read_m1 + (read_m2 & ~write_m2)) each READY cycle, i.e. +0, +1 or +2.
REQ-029 num_writes SHALL add write_m2 each READY cycle.
REQ-030 Both counters SHALL wrap modulo 2^WORD_SIZE.

Reset
REQ-031 When reset_n=0, the block SHALL immediately enter INIT with index=0, mem_ready=0, num_reads=0, num_writes=0, conflict=0, data1=0 and data2 high-Z.
REQ-032 Reset asserted mid-INIT or mid-READY SHALL restart initialisation from index 0 after release, and all memory contents SHALL be overwritten.

Structure
REQ-033 WORD_SIZE, MEM_DEPTH and the INIT/READY state encoding SHALL reside in the shared package and be used by both the CPU and this block.
REQ-034 The INIT/READY FSM and index counter SHALL be one sub-module, memory_init_fsm, outputting mem_ready, the init write enable and the init address.
REQ-035 The storage array, port logic, counters and conflict flag SHALL reside in the top level.

Verification
REQ-036 Release reset with MEM_DEPTH=256 -> mem_ready=0 for 256 cycles, then 1; reads of addresses 0, 128 and 255 return 16'h0000.
REQ-037 Write 16'hBEEF to address2=16'h0012, then read on port 1 at address1=16'h0012 -> data1=16'hBEEF; num_writes=1 and num_reads=1.
REQ-038 Write 16'h1234 to address 16'h0105 with MEM_DEPTH=256 -> a read at address 16'h0005 returns 16'h1234 (wrap).
REQ-039 read_m2=1 and write_m2=1 together with bus value 16'hA5A5 at address 3 -> data2 not driven by the block, mem[3]=16'hA5A5, conflict=1 and it stays 1.
REQ-040 read_m1=1 and read_m2=1 in one cycle for 10 cycles -> num_reads=20; then reset_n pulsed low at cycle 50 of a second INIT -> counters=0, INIT restarts, mem_ready rises 256 cycles after release.

Source files
------------

// File: rtl/dual_port_memory_pkg.sv
// Shared sizing and memory-state encoding.
// Used by the dual-port memory and by the CPU that talks to it.
package dual_port_memory_pkg;

  localparam int WORD_SIZE = 16;
  localparam int MEM_DEPTH = 256;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } mem_state_t;

endpackage

// File: rtl/memory_init_fsm.sv
// INIT/READY sequencer: sweeps every word index once after reset,
// then raises mem_ready and stays there until the next reset.
module memory_init_fsm
  import dual_port_memory_pkg::*;
#(
  parameter int MEM_DEPTH = dual_port_memory_pkg::MEM_DEPTH,
  parameter int ADDR_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_ready,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MEM_DEPTH - 1);

  mem_state_t        state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic              ready_reg;
  logic              we_reg;

  // The write enable is already high while reset is held, so the first
  // edge after release writes word 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_INIT;
      idx_reg   <= '0;
      ready_reg <= 1'b0;
      we_reg    <= 1'b1;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_READY;
            idx_reg   <= '0;
            ready_reg <= 1'b1;
            we_reg    <= 1'b0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_READY: begin
          state_reg <= ST_READY;
        end
        default: begin
          state_reg <= ST_INIT;
        end
      endcase
    end
  end

  assign mem_ready = ready_reg;
  assign init_we   = we_reg;
  assign init_addr = idx_reg;

endmodule

// File: rtl/dual_port_memory.sv
// Dual-port word memory: combinational read-only instruction port and a
// bidirectional read/write data port, with access counters and a conflict flag.
module dual_port_memory
  import dual_port_memory_pkg::*;
#(
  parameter int WORD_SIZE                    = dual_port_memory_pkg::WORD_SIZE,
  parameter int MEM_DEPTH                    = dual_port_memory_pkg::MEM_DEPTH,
  parameter logic [WORD_SIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 read_m1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  input  logic                 read_m2,
  input  logic                 write_m2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic                 mem_ready,
  output logic [WORD_SIZE-1:0] num_reads,
  output logic [WORD_SIZE-1:0] num_writes,
  output logic                 conflict
);

  localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [WORD_SIZE-1:0] mem [MEM_DEPTH];

  logic                 init_we;
  logic [ADDR_W-1:0]    init_addr;
  logic [ADDR_W-1:0]    idx1;
  logic [ADDR_W-1:0]    idx2;
  logic                 rd2_accept;
  logic                 wr2_accept;
  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic [1:0]           rd_inc;
  logic [WORD_SIZE-1:0] num_reads_reg;
  logic [WORD_SIZE-1:0] num_writes_reg;
  logic                 conflict_reg;

  memory_init_fsm #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_init_fsm (
    .clk       (clk),
    .reset_n   (reset_n),
    .mem_ready (mem_ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  // Upper address bits are deliberately ignored so addresses wrap.
  assign idx1 = address1[ADDR_W-1:0];
  assign idx2 = address2[ADDR_W-1:0];

  generate
    if (ADDR_W < WORD_SIZE) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^{address1[WORD_SIZE-1:ADDR_W], address2[WORD_SIZE-1:ADDR_W]};
    end
  endgenerate

  // A simultaneous read+write on port 2 is treated as a write only.
  assign rd2_accept = mem_ready & read_m2 & ~write_m2;
  assign wr2_accept = mem_ready & write_m2;

  assign data1 = (mem_ready && read_m1) ? mem[idx1] : '0;
  assign data2 = rd2_accept ? mem[idx2] : {WORD_SIZE{1'bz}};

  assign wr_en   = init_we | wr2_accept;
  assign wr_addr = init_we ? init_addr : idx2;
  assign wr_data = init_we ? INIT_VALUE : data2;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_inc = {1'b0, mem_ready & read_m1} + {1'b0, rd2_accept};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      num_reads_reg  <= '0;
      num_writes_reg <= '0;
      conflict_reg   <= 1'b0;
    end else if (mem_ready) begin
      num_reads_reg  <= num_reads_reg + WORD_SIZE'(rd_inc);
      num_writes_reg <= num_writes_reg + WORD_SIZE'(write_m2);
      conflict_reg   <= conflict_reg | (read_m2 & write_m2);
    end
  end

  assign num_reads  = num_reads_reg;
  assign num_writes = num_writes_reg;
  assign conflict   = conflict_reg;

endmodule

// File: tb/tb_dual_port_memory.sv
// Bench for dual_port_memory: vector table plus hand-written reset,
// initialisation and conflict sequences, checked through a scoreboard queue.
module tb_dual_port_memory;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        read_m1 = 1'b0;
  logic        read_m2 = 1'b0;
  logic        write_m2 = 1'b0;
  logic [15:0] address1 = '0;
  logic [15:0] address2 = '0;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_wdata = '0;
  wire  [15:0] data2;
  logic [15:0] data1;
  logic [15:0] num_reads;
  logic [15:0] num_writes;
  logic        mem_ready;
  logic        conflict;

  assign data2 = tb_drv ? tb_wdata : 16'hzzzz;

  dual_port_memory dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .read_m1    (read_m1),
    .address1   (address1),
    .data1      (data1),
    .read_m2    (read_m2),
    .write_m2   (write_m2),
    .address2   (address2),
    .data2      (data2),
    .mem_ready  (mem_ready),
    .num_reads  (num_reads),
    .num_writes (num_writes),
    .conflict   (conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd1;
    logic [15:0] a1;
    logic        rd2;
    logic        wr2;
    logic [15:0] a2;
    logic [15:0] wd;
    logic [15:0] exp1;
    logic [15:0] exp2;
    logic [15:0] exp_reads;
    logic [15:0] exp_writes;
  } vec_t;

  typedef struct {
    bit          port2;
    logic [15:0] exp;
    string       name;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[8];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic rd1, input logic [15:0] a1, input logic rd2,
                              input logic wr2, input logic [15:0] a2, input logic [15:0] wd,
                              input logic [15:0] e1, input logic [15:0] e2,
                              input logic [15:0] er, input logic [15:0] ew);
    vec_t v;
    v.rd1 = rd1; v.a1 = a1; v.rd2 = rd2; v.wr2 = wr2; v.a2 = a2; v.wd = wd;
    v.exp1 = e1; v.exp2 = e2; v.exp_reads = er; v.exp_writes = ew;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // One bus cycle: drive at negedge, compare combinational reads before the
  // rising edge, then compare the counters just after it.
  task automatic drive_cycle(input vec_t v, input string tag);
    @(negedge clk);
    read_m1  = v.rd1;
    address1 = v.a1;
    read_m2  = v.rd2;
    write_m2 = v.wr2;
    address2 = v.a2;
    tb_drv   = v.wr2;
    tb_wdata = v.wd;
    sbq.push_back('{port2: 1'b0, exp: v.exp1, name: {tag, ".data1"}});
    if (v.rd2)
      sbq.push_back('{port2: 1'b1, exp: (v.wr2 ? v.wd : v.exp2), name: {tag, ".data2"}});
    #2;
    while (sbq.size() > 0) begin
      sb_t e;
      e = sbq.pop_front();
      check(e.name, e.port2 ? data2 : data1, e.exp);
    end
    @(posedge clk);
    #1;
    check({tag, ".num_reads"}, num_reads, v.exp_reads);
    check({tag, ".num_writes"}, num_writes, v.exp_writes);
  endtask

  task automatic idle();
    @(negedge clk);
    read_m1 = 1'b0; read_m2 = 1'b0; write_m2 = 1'b0;
    address1 = '0; address2 = '0; tb_drv = 1'b0; tb_wdata = '0;
  endtask

  // Counts rising edges until mem_ready, continuing from already_elapsed.
  task automatic wait_ready(input int already_elapsed, input string tag);
    int n;
    n = 0;
    for (int i = already_elapsed + 1; i <= 1000; i++) begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        n = i;
        break;
      end
    end
    check({tag, ".ready_latency"}, 16'(n), 16'd256);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".mem_ready"}, 16'(mem_ready), 16'd0);
    check({tag, ".num_reads"}, num_reads, 16'd0);
    check({tag, ".num_writes"}, num_writes, 16'd0);
    check({tag, ".conflict"}, 16'(conflict), 16'd0);
  endtask

  initial begin
    tbl[0] = mk(1, 16'h0000, 1, 0, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'd2,  16'd0);
    tbl[1] = mk(1, 16'h00FF, 0, 1, 16'h0012, 16'hBEEF, 16'h0000, 16'h0000, 16'd3,  16'd1);
    tbl[2] = mk(1, 16'h0012, 0, 0, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'd4,  16'd1);
    tbl[3] = mk(1, 16'h0040, 0, 1, 16'h0105, 16'h1234, 16'h0000, 16'h0000, 16'd5,  16'd2);
    tbl[4] = mk(1, 16'h0005, 1, 0, 16'h0105, 16'h0000, 16'h1234, 16'h1234, 16'd7,  16'd2);
    tbl[5] = mk(1, 16'h0020, 0, 1, 16'h0020, 16'h5555, 16'h0000, 16'h0000, 16'd8,  16'd3);
    tbl[6] = mk(1, 16'h0020, 1, 0, 16'h0012, 16'h0000, 16'h5555, 16'hBEEF, 16'd10, 16'd3);
    tbl[7] = mk(0, 16'h0012, 1, 0, 16'h0020, 16'h0000, 16'h0000, 16'h5555, 16'd11, 16'd3);

    // Reset held with a read request pending.
    reset_n = 1'b0;
    read_m1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    check("reset.data1", data1, 16'h0000);

    // INIT with requests asserted: nothing may be read, written or counted.
    @(negedge clk);
    reset_n  = 1'b1;
    read_m1  = 1'b1; address1 = 16'h0040;
    write_m2 = 1'b1; address2 = 16'h0040;
    tb_drv   = 1'b1; tb_wdata = 16'hDEAD;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if (i == 50) check("init.data1", data1, 16'h0000);
      if (i == 100) check("init.mem_ready", 16'(mem_ready), 16'd0);
    end
    read_m1 = 1'b0; write_m2 = 1'b0; tb_drv = 1'b0;
    wait_ready(100, "init1");
    check("init1.num_reads", num_reads, 16'd0);
    check("init1.num_writes", num_writes, 16'd0);

    for (int i = 0; i < 8; i++) drive_cycle(tbl[i], $sformatf("vec%0d", i));
    check("vec.conflict", 16'(conflict), 16'd0);

    // Read+write together on port 2: write wins, bus keeps the requester value.
    drive_cycle(mk(0, 16'h0000, 0, 1, 16'h0003, 16'h1111, 16'h0000, 16'h0000, 16'd11, 16'd4), "pre_conf");
    drive_cycle(mk(0, 16'h0000, 1, 1, 16'h0003, 16'hA5A5, 16'h0000, 16'h0000, 16'd11, 16'd5), "conf");
    check("conf.conflict", 16'(conflict), 16'd1);
    drive_cycle(mk(1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 16'd12, 16'd5), "conf_rd");
    idle();
    repeat (5) @(posedge clk);
    #1;
    check("conf.sticky", 16'(conflict), 16'd1);

    // Asynchronous reset mid-READY, then again 50 cycles into the new INIT.
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1 check_reset_state("rst_ready");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(posedge clk);
    #1 check("init2.mem_ready", 16'(mem_ready), 16'd0);
    #2 reset_n = 1'b0;
    #1 check_reset_state("rst_init");
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready(0, "init3");

    // Ten cycles of reads on both ports.
    for (int k = 0; k < 10; k++)
      drive_cycle(mk(1, 16'(k), 1, 0, 16'(16'h0080 + k), 16'h0000, 16'h0000, 16'h0000,
                     16'(2 * (k + 1)), 16'd0), $sformatf("dual%0d", k));

    // Contents written before the reset must be re-initialised.
    drive_cycle(mk(1, 16'h0012, 1, 0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 16'd22, 16'd0), "reinit_a");
    drive_cycle(mk(1, 16'h0003, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd23, 16'd0), "reinit_b");
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
